// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and default widths for the serial pattern generator.
package seq_gen_pkg;

    localparam int unsigned W_DEF     = 4;
    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned GAP_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: W-bit parallel-load, shift-left register; the MSB is the serial bit.
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);

    logic [W-1:0] r_q;

    // Load has priority over shift; zeros enter at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {r_q[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repeat count.
// Optional inter-repetition idle gap is built when SEQGEN_GAP_EN is defined.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [W-1:0]     load_pattern,
    input  logic [CNT_W-1:0] load_reps,
`ifdef SEQGEN_GAP_EN
    input  logic [GAP_W-1:0] load_gap,
`endif
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BC_W = $clog2(W);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_hold;
    logic [W-1:0]     w_hold_nxt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_nxt;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [BC_W-1:0]  w_bit_nxt;
    logic             r_x_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_load_ready;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_sh_load;
    logic             w_sh_shift;
    logic [W-1:0]     w_sh_data;
`ifdef SEQGEN_GAP_EN
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;
`endif

    assign w_accept = load_valid && r_load_ready;

    // Shift register: its MSB flop is the x output, cleared whenever no bit is sent.
    seq_gen_shreg #(.W(W)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_sh_load),
        .i_shift (w_sh_shift),
        .i_data  (w_sh_data),
        .o_msb   (x)
    );

    // State, counters and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_rep_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_x_valid    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
`ifdef SEQGEN_GAP_EN
            r_gap        <= '0;
            r_gap_cnt    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_rep_cnt    <= w_rep_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_x_valid    <= (w_state_nxt == SHIFT);
            r_busy       <= (w_state_nxt != IDLE);
            r_done       <= w_done_nxt;
            r_load_ready <= (w_state_nxt == IDLE);
`ifdef SEQGEN_GAP_EN
            r_gap        <= w_gap_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
`endif
        end
    end

    // Next-state, counter updates and shift-register controls.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_rep_nxt     = r_rep_cnt;
        w_bit_nxt     = r_bit_cnt;
        w_done_nxt    = 1'b0;
        w_sh_load     = 1'b0;
        w_sh_shift    = 1'b0;
        w_sh_data     = '0;
`ifdef SEQGEN_GAP_EN
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (load_reps != '0) begin
                        w_state_nxt = SHIFT;
                        w_hold_nxt  = load_pattern;
                        w_rep_nxt   = load_reps;
                        w_bit_nxt   = BC_W'(W - 1);
                        w_sh_load   = 1'b1;
                        w_sh_data   = load_pattern;
`ifdef SEQGEN_GAP_EN
                        w_gap_nxt   = load_gap;
`endif
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (r_bit_cnt != '0) begin
                    w_sh_shift = 1'b1;
                    w_bit_nxt  = r_bit_cnt - BC_W'(1);
                end else if (r_rep_cnt == CNT_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_sh_load   = 1'b1;
                end else begin
                    w_rep_nxt = r_rep_cnt - CNT_W'(1);
                    w_bit_nxt = BC_W'(W - 1);
                    w_sh_load = 1'b1;
`ifdef SEQGEN_GAP_EN
                    if (r_gap != '0) begin
                        w_state_nxt   = GAP;
                        w_gap_cnt_nxt = r_gap;
                    end else begin
                        w_sh_data = r_hold;
                    end
`else
                    w_sh_data = r_hold;
`endif
                end
            end
`ifdef SEQGEN_GAP_EN
            GAP: begin
                if (r_gap_cnt == GAP_W'(1)) begin
                    w_state_nxt = SHIFT;
                    w_sh_load   = 1'b1;
                    w_sh_data   = r_hold;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign x_valid    = r_x_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed table plus randomized jobs checked against a stream model.
module tb_seq_pattern_gen;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [W-1:0]     load_pattern;
    logic [CNT_W-1:0] load_reps;
`ifdef SEQGEN_GAP_EN
    logic [3:0]       load_gap;
`endif
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_pattern_gen #(.W(W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_pattern (load_pattern),
        .load_reps    (load_reps),
`ifdef SEQGEN_GAP_EN
        .load_gap     (load_gap),
`endif
        .x            (x),
        .x_valid      (x_valid),
        .busy         (busy),
        .done         (done)
    );

    typedef struct packed {
        logic v;
        logic b;
    } beat_t;

    typedef struct {
        logic [W-1:0] pattern;
        int           reps;
        int           gap;
        int           exp_bits;
        int           exp_det;
    } vec_t;

    beat_t exp_q[$];

    // Expected serial stream of one job: reps copies of the pattern MSB-first, gaps between.
    function automatic void build(input logic [W-1:0] p, input int reps, input int gap);
        exp_q.delete();
        for (int r = 0; r < reps; r++) begin
            for (int i = W - 1; i >= 0; i--) exp_q.push_back('{v: 1'b1, b: p[i]});
            if (r != reps - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back('{v: 1'b0, b: 1'b0});
        end
    endfunction

    task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s {x_valid,x,busy,done,load_ready} got %b want %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {x_valid, x, busy, done, load_ready};
    endfunction

    // Present a job in the current cycle, then follow every beat and the done cycle.
    task automatic run_job(input logic [W-1:0] p, input int reps, input int gap,
                           input bit hold_valid, output int nvalid, output int ndet);
        logic [3:0] win;
        build(p, reps, gap);
        load_pattern = p;
        load_reps    = CNT_W'(reps);
`ifdef SEQGEN_GAP_EN
        load_gap     = 4'(gap);
`endif
        load_valid   = 1'b1;
        step();
        nvalid = 0;
        ndet   = 0;
        win    = '0;
        for (int k = 0; k < exp_q.size(); k++) begin
            chk5("job_beat", outs(), {exp_q[k].v, exp_q[k].b, 3'b100});
            if (x_valid) begin
                nvalid++;
                win = {win[2:0], x};
                if (win == 4'b1011) ndet++;
            end
            load_valid   = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
            load_pattern = W'($urandom);
            load_reps    = CNT_W'($urandom);
            step();
        end
        load_valid = 1'b0;
        chk5("done_cycle", outs(), 5'b00011);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            chk5("idle", outs(), 5'b00001);
        end
    endtask

    vec_t vecs[8];
    int   n_dir;
    int   nv;
    int   nd;
    int   rg;

    initial begin
        n_dir = 6;
        vecs[0] = '{pattern: 4'b1011, reps: 3,  gap: 0, exp_bits: 12, exp_det: 3};
        vecs[1] = '{pattern: 4'b1111, reps: 0,  gap: 0, exp_bits: 0,  exp_det: 0};
        vecs[2] = '{pattern: 4'b1010, reps: 1,  gap: 0, exp_bits: 4,  exp_det: 0};
        vecs[3] = '{pattern: 4'b0110, reps: 1,  gap: 0, exp_bits: 4,  exp_det: 0};
        vecs[4] = '{pattern: 4'b1001, reps: 15, gap: 0, exp_bits: 60, exp_det: 0};
        vecs[5] = '{pattern: 4'b0001, reps: 2,  gap: 0, exp_bits: 8,  exp_det: 0};
`ifdef SEQGEN_GAP_EN
        n_dir = 8;
        vecs[6] = '{pattern: 4'b1011, reps: 2, gap: 3, exp_bits: 8, exp_det: 2};
        vecs[7] = '{pattern: 4'b1011, reps: 2, gap: 0, exp_bits: 8, exp_det: 2};
`endif

        rst          = 1'b1;
        load_valid   = 1'b1;
        load_pattern = 4'b1011;
        load_reps    = 4'd3;
`ifdef SEQGEN_GAP_EN
        load_gap     = 4'd0;
`endif
        step();
        step();
        chk5("reset_state", outs(), 5'b00001);
        rst        = 1'b0;
        load_valid = 1'b0;
        idle_cycles(2);

        // Directed jobs, issued back to back with load_valid held high throughout.
        for (int i = 0; i < n_dir; i++) begin
            run_job(vecs[i].pattern, vecs[i].reps, vecs[i].gap, 1'b1, nv, nd);
            chki("dir_bits", nv, vecs[i].exp_bits);
            chki("dir_detect", nd, vecs[i].exp_det);
        end
        idle_cycles(2);

        // Reset during the third bit of a 1010 x2 job, with load_valid also high.
        load_pattern = 4'b1010;
        load_reps    = 4'd2;
`ifdef SEQGEN_GAP_EN
        load_gap     = 4'd0;
`endif
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk5("rst_bit1", outs(), 5'b11100);
        step();
        step();
        chk5("rst_bit3", outs(), 5'b11100);
        rst        = 1'b1;
        load_valid = 1'b1;
        step();
        chk5("rst_mid_job", outs(), 5'b00001);
        rst        = 1'b0;
        load_valid = 1'b0;
        idle_cycles(6);

        // Randomized jobs with random idle spacing and noisy load_valid while busy.
        for (int j = 0; j < 40; j++) begin
            rg = 0;
`ifdef SEQGEN_GAP_EN
            rg = int'($urandom_range(0, 3));
`endif
            nd = (($urandom_range(0, 9)) == 0) ? 15 : int'($urandom_range(0, 4));
            run_job(W'($urandom), nd, rg, 1'b0, nv, nd);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
